// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Instruction-fetch stage of the pipelined MIPS CPU. It holds the program
// counter, drives the word address to the instruction ROM, and captures the
// returned word into the IF/ID pipeline register. The next PC is one of:
// sequential fetch, a taken beq redirect, or a j redirect. Both redirects are
// resolved in ID. Stall and squash are handled here. A redirect costs one
// bubble, and there are no delay slots.
//
// Parameters
//   RESET_PC        PC loaded on reset (word aligned)
//   NOP_INST        instruction word used as a bubble
//
// Ports
//   i_clk           clock, rising edge
//   i_rst           synchronous active-high reset
//   i_stall         ID hazard: hold PC and IF/ID
//   i_branch_taken  ID resolved a taken beq
//   i_branch_off    beq 16-bit immediate from the instruction in ID
//   i_jump          ID holds a j
//   i_jump_idx      j 26-bit target index from the instruction in ID
//   o_rom_addr      byte address to the ROM (equal to o_pc)
//   i_rom_inst      combinational ROM data for o_rom_addr
//   o_pc            current fetch PC
//   o_id_inst       IF/ID instruction
//   o_id_pc4        IF/ID fetch PC + 4
//   o_id_valid      IF/ID holds a real instruction (not a bubble)
// ---------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [15:0] i_branch_off,
    input  logic        i_jump,
    input  logic [25:0] i_jump_idx,
    output logic [31:0] o_rom_addr,
    input  logic [31:0] i_rom_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_id_inst,
    output logic [31:0] o_id_pc4,
    output logic        o_id_valid
);

    typedef enum logic [1:0] {
        SEL_SEQ    = 2'd0,
        SEL_HOLD   = 2'd1,
        SEL_BRANCH = 2'd2,
        SEL_JUMP   = 2'd3
    } sel_t;

    // PC and IF/ID PC+4 are held as word addresses. This keeps the low two
    // address bits zero by construction.
    logic [29:0] r_pc_w;
    logic [31:0] r_id_inst;
    logic [29:0] r_id_pc4_w;
    logic        r_id_valid;

    logic [29:0] w_pc4_w;
    logic [29:0] w_br_target_w;
    logic [29:0] w_jmp_target_w;
    sel_t        w_sel;

    logic [29:0] w_pc_nxt_w;
    logic [31:0] w_id_inst_nxt;
    logic [29:0] w_id_pc4_nxt_w;
    logic        w_id_valid_nxt;

    assign w_pc4_w = r_pc_w + 30'd1;

    // Redirect targets use the registered PC+4 of the instruction now in ID.
    // This is not the PC currently being fetched.
    assign w_br_target_w  = r_id_pc4_w + {{14{i_branch_off[15]}}, i_branch_off};
    assign w_jmp_target_w = {r_id_pc4_w[29:26], i_jump_idx};

    // Priority: jump > branch > stall > sequential. A redirect raised
    // against a bubble in ID is meaningless, so it only counts when IF/ID
    // holds a real instruction.
    always_comb begin
        w_sel = SEL_SEQ;
        if (i_jump && r_id_valid) begin
            w_sel = SEL_JUMP;
        end else if (i_branch_taken && r_id_valid) begin
            w_sel = SEL_BRANCH;
        end else if (i_stall) begin
            w_sel = SEL_HOLD;
        end
    end

    always_comb begin
        w_pc_nxt_w     = r_pc_w;
        w_id_inst_nxt  = r_id_inst;
        w_id_pc4_nxt_w = r_id_pc4_w;
        w_id_valid_nxt = r_id_valid;
        case (w_sel)
            SEL_SEQ: begin
                w_pc_nxt_w     = w_pc4_w;
                w_id_inst_nxt  = i_rom_inst;
                w_id_pc4_nxt_w = w_pc4_w;
                w_id_valid_nxt = 1'b1;
            end
            SEL_HOLD: begin
                w_pc_nxt_w     = r_pc_w;
            end
            SEL_BRANCH: begin
                // Squash the wrong-path fetch currently in IF.
                w_pc_nxt_w     = w_br_target_w;
                w_id_inst_nxt  = NOP_INST;
                w_id_pc4_nxt_w = 30'd0;
                w_id_valid_nxt = 1'b0;
            end
            SEL_JUMP: begin
                w_pc_nxt_w     = w_jmp_target_w;
                w_id_inst_nxt  = NOP_INST;
                w_id_pc4_nxt_w = 30'd0;
                w_id_valid_nxt = 1'b0;
            end
            default: begin
                w_pc_nxt_w     = r_pc_w;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc_w     <= RESET_PC[31:2];
            r_id_inst  <= NOP_INST;
            r_id_pc4_w <= 30'd0;
            r_id_valid <= 1'b0;
        end else begin
            r_pc_w     <= w_pc_nxt_w;
            r_id_inst  <= w_id_inst_nxt;
            r_id_pc4_w <= w_id_pc4_nxt_w;
            r_id_valid <= w_id_valid_nxt;
        end
    end

    assign o_pc       = {r_pc_w, 2'b00};
    assign o_rom_addr = {r_pc_w, 2'b00};
    assign o_id_inst  = r_id_inst;
    assign o_id_pc4   = {r_id_pc4_w, 2'b00};
    assign o_id_valid = r_id_valid;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage of the pipelined MIPS CPU, directly upstream of `INST_ROM`. Holds the program counter, drives the ROM word address, and captures the returned instruction into the IF/ID pipeline register. Next-PC selection covers sequential fetch, ID-resolved `beq` redirect and `j` redirect, with stall and squash control. Redirect penalty is one bubble; there are no delay slots.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; word-aligned.
- `NOP_INST`, default 32'h0000_0000: instruction word inserted as a bubble.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `stall`  in  1: ID hazard; hold PC and IF/ID.
- `branch_taken`  in  1: ID has resolved a taken `beq`.
- `branch_off`  in  16: `beq` immediate from the instruction in ID.
- `jump`  in  1: ID holds a `j`.
- `jump_idx`  in  26: `j` target index from the instruction in ID.
- `rom_addr`  out  32: byte address to `INST_ROM`, equal to `pc`.
- `rom_inst`  in  32: combinational ROM data for `rom_addr`.
- `pc`  out  32: current fetch PC.
- `id_inst`  out  32: IF/ID instruction.
- `id_pc4`  out  32: IF/ID fetch PC + 4.
- `id_valid`  out  1: IF/ID holds a real instruction, not a bubble.

## Operation
- `pc4 = pc + 4`, modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Branch target: `id_pc4 + ({{14{branch_off[15]}}, branch_off, 2'b00})`, 32-bit wrap.
- Jump target: `{id_pc4[31:28], jump_idx, 2'b00}`.
- Redirect targets come from the registered `id_pc4`, because the redirecting instruction is in ID.
- Per-edge priority, highest first:
  - `rst`: `pc <= RESET_PC`, `id_inst <= NOP_INST`, `id_pc4 <= 0`, `id_valid <= 0`.
  - `jump`: `pc <= jump target`; IF/ID takes the bubble `NOP_INST`, `id_pc4 <= 0`, `id_valid <= 0`. This squashes the wrong-path fetch.
  - `branch_taken`: same as `jump`, using the branch target.
  - `stall`: `pc`, `id_inst`, `id_pc4` and `id_valid` hold.
  - Normal: `pc <= pc4`, `id_inst <= rom_inst`, `id_pc4 <= pc4`, `id_valid <= 1`.
- `jump` and `branch_taken` together: `jump` wins.
- Redirect together with `stall`: the redirect wins and `stall` is ignored.
- `jump`/`branch_taken` are honoured only when `id_valid` = 1. Asserted against a bubble, they are ignored and the edge follows `stall` or normal.
- `pc[1:0]` is always 0. `rom_addr[1:0]` is 0.

## Timing
- Reset values: `pc` = `rom_addr` = `RESET_PC`, `id_inst` = `NOP_INST`, `id_pc4` = 0, `id_valid` = 0.
- Reset asserted mid-operation takes effect at the next edge and overrides all other inputs.
- `rom_addr` is combinational from `pc`, with zero latency. `rom_inst` must settle within the same cycle.
- Fetch-to-ID latency: 1 edge.
- Redirect: the taken instruction is in ID during cycle k. The target is in `pc` at cycle k+1, and the target instruction is in ID at cycle k+2. This costs exactly one bubble.
- A stall held for N cycles freezes the stage for N edges. No fetch is lost and none is duplicated.

## Test plan
- Reset then release with default ROM: `pc` sequence is 0x00 → 0x04. ID holds `j 5H` (32'h0800_0005) with `jump` asserted, so `pc` goes to 0x14. `id_valid` is 0 for one cycle, then `id_inst` = 32'h3401_1234.
- Sequential fetch 0x14 to 0x40: `id_pc4` trails `pc` by one edge. Each `id_inst` matches ROM words 0x05 to 0x10, and `id_valid` stays 1.
- `beq` at 0x44 (`id_pc4` = 0x48) with `branch_off` = 16'hFFEE and `branch_taken` = 1: next `pc` = 0x0000_0000, then one bubble. Not-taken `beq` at 0x40 gives `pc` = 0x48 with no bubble.
- `stall` high for 3 cycles at `pc` = 0x20: `pc`, `id_inst` and `id_pc4` are unchanged for 3 edges, then resume at 0x24.
- `jump`, `branch_taken` and `stall` all high together: the jump target is taken and the bubble is inserted. Redirect with `id_valid` = 0: ignored, `pc` advances by 4.
- `rst` asserted during a stall with `pc` = 0x30: the next edge gives `pc` = 0, `id_valid` = 0. Force `pc` = 32'hFFFF_FFFC: the next `pc` is 0 and `id_pc4` = 0.
